hack_kbd_rx: RTL and testbench

PS/2 keyboard receiver feeding the Hack keyboard memory-map word (KBD, address 0x6000). It deserialises PS/2 scan-code set 2 frames and tracks make, break and E0 prefixes. It presents the Hack key code of the currently held key on a 16-bit output, with 0 when no key is held. The CPU reads `kbd_out` through the memory read mux. This block is the device-side writer of that word; the CPU side only reads it.

---
 rtl/hack_kbd_pkg.sv | 80 ++++++++
 rtl/ps2_frame_rx.sv | 121 ++++++++++++
 rtl/hack_kbd_rx.sv | 81 ++++++++
 tb/tb_hack_kbd_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_kbd_pkg.sv
// Shared types and the PS/2 set 2 to Hack key-code lookup for the keyboard receiver.
// Pure declarations; no state.
package hack_kbd_pkg;

    typedef enum logic [1:0] {FR_IDLE, FR_DATA, FR_PARITY, FR_STOP} frame_state_t;
    typedef enum logic [1:0] {DEC_NORM, DEC_E0, DEC_F0, DEC_E0F0} dec_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;

    localparam logic [7:0] KEY_SPACE     = 8'd32;
    localparam logic [7:0] KEY_ENTER     = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;
    localparam logic [7:0] KEY_F12       = 8'd152;

    // Returns 0 for any code without a Hack equivalent.
    function automatic logic [7:0] ps2_to_hack(input logic ext, input logic [7:0] code);
        logic [7:0] k;
        k = 8'd0;
        if (ext) begin
            case (code)
                8'h6B: k = KEY_LEFT;
                8'h75: k = KEY_UP;
                8'h74: k = KEY_RIGHT;
                8'h72: k = KEY_DOWN;
                8'h6C: k = KEY_HOME;
                8'h69: k = KEY_END;
                8'h7D: k = KEY_PGUP;
                8'h7A: k = KEY_PGDN;
                8'h70: k = KEY_INSERT;
                8'h71: k = KEY_DELETE;
                default: k = 8'd0;
            endcase
        end else begin
            case (code)
                8'h1C: k = 8'd65;  8'h32: k = 8'd66;  8'h21: k = 8'd67;  8'h23: k = 8'd68;
                8'h24: k = 8'd69;  8'h2B: k = 8'd70;  8'h34: k = 8'd71;  8'h33: k = 8'd72;
                8'h43: k = 8'd73;  8'h3B: k = 8'd74;  8'h42: k = 8'd75;  8'h4B: k = 8'd76;
                8'h3A: k = 8'd77;  8'h31: k = 8'd78;  8'h44: k = 8'd79;  8'h4D: k = 8'd80;
                8'h15: k = 8'd81;  8'h2D: k = 8'd82;  8'h1B: k = 8'd83;  8'h2C: k = 8'd84;
                8'h3C: k = 8'd85;  8'h2A: k = 8'd86;  8'h1D: k = 8'd87;  8'h22: k = 8'd88;
                8'h35: k = 8'd89;  8'h1A: k = 8'd90;
                8'h45: k = 8'd48;  8'h16: k = 8'd49;  8'h1E: k = 8'd50;  8'h26: k = 8'd51;
                8'h25: k = 8'd52;  8'h2E: k = 8'd53;  8'h36: k = 8'd54;  8'h3D: k = 8'd55;
                8'h3E: k = 8'd56;  8'h46: k = 8'd57;
                8'h29: k = KEY_SPACE;
                8'h5A: k = KEY_ENTER;
                8'h66: k = KEY_BACKSPACE;
                8'h76: k = KEY_ESC;
                8'h05: k = KEY_F1;
                8'h06: k = KEY_F1 + 8'd1;
                8'h04: k = KEY_F1 + 8'd2;
                8'h0C: k = KEY_F1 + 8'd3;
                8'h03: k = KEY_F1 + 8'd4;
                8'h0B: k = KEY_F1 + 8'd5;
                8'h83: k = KEY_F1 + 8'd6;
                8'h0A: k = KEY_F1 + 8'd7;
                8'h01: k = KEY_F1 + 8'd8;
                8'h09: k = KEY_F1 + 8'd9;
                8'h78: k = KEY_F1 + 8'd10;
                8'h07: k = KEY_F12;
                default: k = 8'd0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronise, glitch-filter ps2_clk, deserialise 11-bit frames, check parity/stop/timeout.
// Latency: scan_valid/frame_err one cycle after the filtered stop-bit fall (2+FILTER_LEN cycles after the raw fall).
// Backpressure: none; the device clocks the data, each good byte is a single-cycle pulse.
module ps2_frame_rx
    import hack_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          filt_done;
    logic          fall;
    logic          data_bit;
    logic          timed_out;

    frame_state_t  state;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic          par_q;
    logic [TW-1:0] to_cnt;

    // Everything clears to 0; the idle-high line then shows up as a rise, which is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b00;
            dat_sync <= 2'b00;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign data_bit  = dat_sync[1];
    assign filt_done = (filt_cnt == FW'(FILTER_LEN - 1));
    assign fall      = clk_filt && !clk_sync[1] && filt_done;
    assign timed_out = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b0;
            filt_cnt <= '0;
        end else if (clk_sync[1] != clk_filt) begin
            if (filt_done) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FR_IDLE;
            shift_q    <= 8'd0;
            bit_cnt    <= 3'd0;
            par_q      <= 1'b0;
            to_cnt     <= '0;
            scan_valid <= 1'b0;
            scan_code  <= 8'd0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == FR_IDLE) begin
                to_cnt <= '0;
                if (fall && !data_bit) begin
                    state   <= FR_DATA;
                    bit_cnt <= 3'd0;
                end
            end else if (fall) begin
                to_cnt <= '0;
                case (state)
                    FR_DATA: begin
                        shift_q <= {data_bit, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= FR_PARITY;
                    end
                    FR_PARITY: begin
                        par_q <= data_bit;
                        state <= FR_STOP;
                    end
                    FR_STOP: begin
                        if ((^{shift_q, par_q}) && data_bit) begin
                            scan_valid <= 1'b1;
                            scan_code  <= shift_q;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= FR_IDLE;
                    end
                    default: state <= FR_IDLE;
                endcase
            end else if (timed_out) begin
                frame_err <= 1'b1;
                state     <= FR_IDLE;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/hack_kbd_rx.sv
// Hack KBD word writer: decodes make/break/E0 sequences from PS/2 bytes into the held-key code.
// Latency: kbd_out updates one cycle after scan_valid.
// Backpressure: none; the CPU only reads kbd_out.
module hack_kbd_rx
    import hack_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kbd_out,
    output logic        scan_valid,
    output logic [7:0]  scan_code,
    output logic        frame_err
);

    dec_state_t dec_state;
    logic [7:0] key_q;
    logic [7:0] hack_n;
    logic [7:0] hack_e;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    assign hack_n  = ps2_to_hack(1'b0, scan_code);
    assign hack_e  = ps2_to_hack(1'b1, scan_code);
    assign kbd_out = {8'h00, key_q};

    // Last make wins; a break only clears if it releases the key currently shown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_state <= DEC_NORM;
            key_q     <= 8'd0;
        end else if (scan_valid) begin
            case (dec_state)
                DEC_NORM: begin
                    if (scan_code == PS2_EXT)
                        dec_state <= DEC_E0;
                    else if (scan_code == PS2_BREAK)
                        dec_state <= DEC_F0;
                    else if (hack_n != 8'd0)
                        key_q <= hack_n;
                end
                DEC_E0: begin
                    if (scan_code == PS2_BREAK) begin
                        dec_state <= DEC_E0F0;
                    end else begin
                        if (hack_e != 8'd0)
                            key_q <= hack_e;
                        dec_state <= DEC_NORM;
                    end
                end
                DEC_F0: begin
                    if (hack_n == key_q)
                        key_q <= 8'd0;
                    dec_state <= DEC_NORM;
                end
                DEC_E0F0: begin
                    if (hack_e == key_q)
                        key_q <= 8'd0;
                    dec_state <= DEC_NORM;
                end
                default: dec_state <= DEC_NORM;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_kbd_rx.sv
// Bench for hack_kbd_rx: directed PS/2 sequences plus random byte streams against a key-state model.
module tb_hack_kbd_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int HALF           = 15;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] kbd_out;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        frame_err;

    hack_kbd_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kbd_out   (kbd_out),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sv     = 0;
    int n_err    = 0;

    logic [7:0] map_n [logic [7:0]];
    logic [7:0] map_e [logic [7:0]];
    logic [7:0] let_tab [26];
    logic [7:0] dig_tab [10];
    logic [7:0] fk_tab  [12];
    logic [7:0] ext_tab [10];

    logic [7:0] exp_q [$];
    logic [7:0] m_kbd = 8'd0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       pend  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hack_of(input logic ext, input logic [7:0] c);
        if (ext)
            return map_e.exists(c) ? map_e[c] : 8'd0;
        return map_n.exists(c) ? map_n[c] : 8'd0;
    endfunction

    // Reference: prefix flags plus the held key, advanced per good byte.
    always @(negedge clk) begin
        if (!reset) begin
            m_kbd = 8'd0; m_ext = 1'b0; m_brk = 1'b0; pend = 1'b0;
            exp_q.delete();
        end else begin
            if (pend) begin
                check_eq("kbd_after_byte", kbd_out, {8'h00, m_kbd});
                pend = 1'b0;
            end
            if (frame_err) n_err++;
            if (scan_valid) begin
                logic [7:0] b;
                logic [7:0] k;
                n_sv++;
                check_eq("fe_with_sv", frame_err, 0);
                check_eq("sv_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check_eq("scan_code", scan_code, b);
                    check_eq("kbd_before_update", kbd_out, {8'h00, m_kbd});
                    if (m_brk) begin
                        if (hack_of(m_ext, b) == m_kbd) m_kbd = 8'd0;
                        m_ext = 1'b0; m_brk = 1'b0;
                    end else if (b == 8'hF0) begin
                        m_brk = 1'b1;
                    end else if (b == 8'hE0 && !m_ext) begin
                        m_ext = 1'b1;
                    end else begin
                        k = hack_of(m_ext, b);
                        if (k != 8'd0) m_kbd = k;
                        m_ext = 1'b0;
                    end
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        int   sv0;
        int   fe0;
        logic good;
        good = !bad_par && !bad_stop;
        sv0  = n_sv;
        fe0  = n_err;
        if (good) exp_q.push_back(b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(!bad_stop);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("sv_count", n_sv - sv0, {31'd0, good});
        check_eq("fe_count", n_err - fe0, {31'd0, !good});
    endtask

    initial begin
        int         sv0;
        int         fe0;
        logic [7:0] b;
        int         r;

        let_tab = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        dig_tab = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        fk_tab  = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
        ext_tab = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
        for (int i = 0; i < 26; i++) map_n[let_tab[i]] = 8'(65 + i);
        for (int i = 0; i < 10; i++) map_n[dig_tab[i]] = 8'(48 + i);
        for (int i = 0; i < 12; i++) map_n[fk_tab[i]]  = 8'(141 + i);
        for (int i = 0; i < 10; i++) map_e[ext_tab[i]] = 8'(130 + i);
        map_n[8'h29] = 8'd32;  map_n[8'h5A] = 8'd128;
        map_n[8'h66] = 8'd129; map_n[8'h76] = 8'd140;

        repeat (3) @(negedge clk);
        check_eq("rst_kbd_out", kbd_out, 0);
        check_eq("rst_scan_code", scan_code, 0);
        check_eq("rst_scan_valid", scan_valid, 0);
        check_eq("rst_frame_err", frame_err, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h1C, 0, 0); check_eq("make_A", kbd_out, 65);
        send_frame(8'hF0, 0, 0); check_eq("F0_no_change", kbd_out, 65);
        send_frame(8'h1C, 0, 0); check_eq("break_A", kbd_out, 0);

        send_frame(8'hE0, 0, 0); check_eq("E0_no_change", kbd_out, 0);
        send_frame(8'h75, 0, 0); check_eq("make_up", kbd_out, 131);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0); check_eq("E0F0_no_change", kbd_out, 131);
        send_frame(8'h75, 0, 0); check_eq("break_up", kbd_out, 0);

        send_frame(8'h1C, 1, 0); check_eq("bad_parity_kbd", kbd_out, 0);
        send_frame(8'h5A, 0, 0); check_eq("make_enter", kbd_out, 128);
        send_frame(8'h29, 0, 1); check_eq("bad_stop_kbd", kbd_out, 128);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h5A, 0, 0); check_eq("break_enter", kbd_out, 0);

        send_frame(8'h1C, 0, 0); check_eq("rollover_A", kbd_out, 65);
        send_frame(8'h29, 0, 0); check_eq("rollover_space", kbd_out, 32);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0); check_eq("stale_break_kept", kbd_out, 32);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h29, 0, 0); check_eq("break_space", kbd_out, 0);

        // Truncated frame: start + 3 data bits, the last fall times the timeout.
        fe0 = n_err;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        for (int k = 1; k <= 2 + FILTER_LEN + TIMEOUT_CYCLES; k++) begin
            @(negedge clk);
            if (k == HALF) ps2_clk = 1'b1;
            if (k == 2 + FILTER_LEN + TIMEOUT_CYCLES - 1) check_eq("timeout_early", frame_err, 0);
        end
        check_eq("timeout_fire", frame_err, 1);
        repeat (5) @(negedge clk);
        check_eq("timeout_count", n_err - fe0, 1);
        send_frame(8'h16, 0, 0); check_eq("after_timeout_1", kbd_out, 49);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h16, 0, 0); check_eq("break_1", kbd_out, 0);

        sv0 = n_sv; fe0 = n_err;
        @(negedge clk);
        ps2_data = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        ps2_data = 1'b1;
        repeat (TIMEOUT_CYCLES + 20) @(negedge clk);
        check_eq("glitch_sv", n_sv - sv0, 0);
        check_eq("glitch_fe", n_err - fe0, 0);
        send_frame(8'h1C, 0, 0); check_eq("after_glitch_A", kbd_out, 65);

        // Reset mid-frame with an E0 prefix pending.
        send_frame(8'hE0, 0, 0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("arst_kbd_out", kbd_out, 0);
        check_eq("arst_scan_code", scan_code, 0);
        check_eq("arst_scan_valid", scan_valid, 0);
        check_eq("arst_frame_err", frame_err, 0);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h75, 0, 0); check_eq("prefix_dropped", kbd_out, 0);
        send_frame(8'h1C, 0, 0); check_eq("after_reset_A", kbd_out, 65);

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      b = 8'hE0;
            else if (r < 3) b = 8'hF0;
            else if (r < 5) b = let_tab[$urandom_range(0, 25)];
            else if (r < 6) b = ext_tab[$urandom_range(0, 9)];
            else            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0)
                send_frame(b, 1'($urandom_range(0, 1)), 1'b1);
            else
                send_frame(b, 1'b0, 1'b0);
            check_eq("rand_kbd", kbd_out, {8'h00, m_kbd});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
